data_memory_arbiter: RTL and testbench

// - Shares one data memory port between two requesters (0: core datapath, 1: DMA/debug) using round-robin.
// - Memory side drives addr/write_enable/write_data/valid and consumes read_data/ready.
// - One transaction outstanding at a time; each accepted request gets exactly one rsp_valid pulse (read data or write ack).

---
 rtl/data_memory_arbiter.sv | 152 +++++++++++++++
 tb/tb_data_memory_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one data memory port between two requesters, one transaction in flight.
// Define DATA_MEMORY_ARBITER_STATS_EN to add the grant/conflict statistics counters.
module data_memory_arbiter #(
  parameter int ADDR_SIZE    = 32,
  parameter int DATA_SIZE    = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [1:0]             req_we,
  input  logic [2*DATA_SIZE-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic [ADDR_SIZE-1:0]   mem_addr,
  output logic                   mem_write_enable,
  output logic [DATA_SIZE-1:0]   mem_write_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  output logic [31:0]            grant_count0,
  output logic [31:0]            grant_count1,
  output logic [31:0]            conflict_count,
`endif
  input  logic [DATA_SIZE-1:0]   mem_read_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int unsigned CNT_INIT = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

  logic [1:0]           state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic [1:0]           cnt_q, cnt_d;

  logic gsel;
  logic hs;

  // Contention goes to the requester that did not win last; a lone requester always wins.
  always_comb begin
    if (&req_valid) gsel = ~last_q;
    else            gsel = req_valid[1];
  end

  assign req_ready = (state_q == IDLE && |req_valid) ? (gsel ? 2'b10 : 2'b01) : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          owner_d = gsel;
          last_d  = gsel;
          we_d    = gsel ? req_we[1] : req_we[0];
          addr_d  = gsel ? req_addr[ADDR_SIZE +: ADDR_SIZE] : req_addr[0 +: ADDR_SIZE];
          wdata_d = gsel ? req_wdata[DATA_SIZE +: DATA_SIZE] : req_wdata[0 +: DATA_SIZE];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (we_q) begin
            state_d = RESP;
          end else if (READ_LATENCY == 0) begin
            rdata_d = mem_read_data;
            state_d = RESP;
          end else begin
            cnt_d   = 2'(CNT_INIT);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_read_data;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_valid        = (state_q == ISSUE);
  assign mem_write_enable = mem_valid & we_q;
  assign mem_addr         = addr_q;
  assign mem_write_data   = wdata_q;
  assign rsp_valid        = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : '0;
  assign rsp_rdata        = rdata_q;

`ifdef DATA_MEMORY_ARBITER_STATS_EN
  logic [31:0] gc0_q, gc1_q, conf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      gc0_q  <= '0;
      gc1_q  <= '0;
      conf_q <= '0;
    end else if (hs) begin
      if (req_ready[0]) gc0_q <= gc0_q + 32'd1;
      if (req_ready[1]) gc1_q <= gc1_q + 32'd1;
      if (&req_valid)   conf_q <= conf_q + 32'd1;
    end
  end

  assign grant_count0   = gc0_q;
  assign grant_count1   = gc1_q;
  assign conflict_count = conf_q;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: memory model with configurable latency/stalls,
// reference arbitration model predicting grants, response data, latency and issue cycles.
module tb_data_memory_arbiter;
  parameter int RL = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_we;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_read_data;
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  logic [31:0] grant_count0, grant_count1, conflict_count;
`endif

  always #5 clk = ~clk;

  data_memory_arbiter #(.ADDR_SIZE(32), .DATA_SIZE(32), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    .grant_count0(grant_count0), .grant_count1(grant_count1), .conflict_count(conflict_count),
`endif
    .mem_read_data(mem_read_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 32'hCAFE_0001;
    return 32'h5A00_0000 ^ {a, a, 8'h3C, a};
  endfunction

  // ---------------- memory model ----------------
  logic [31:0] mem [0:255];
  logic [255:0] written = '0;
  logic [31:0] rd_pipe [0:3];
  int unsigned stall_req = 0;
  int unsigned stall_left = 0;

  assign mem_ready     = (stall_left == 0);
  assign mem_read_data = (RL == 0) ? (written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]))
                                   : rd_pipe[(RL == 0) ? 0 : RL - 1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_valid && mem_ready && mem_write_enable) begin
      mem[mem_addr[7:0]]     <= mem_write_data;
      written[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_valid && mem_ready && !mem_write_enable)
      rd_pipe[0] <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    else
      rd_pipe[0] <= 32'hBAD0_0000 ^ cyc;
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
    rd_pipe[3] <= rd_pipe[2];
    if (|(req_valid & req_ready)) stall_left <= stall_req;
    else if (mem_valid && stall_left != 0) stall_left <= stall_left - 1;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          hs_cyc;
    int          stall;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        cur;
  logic [31:0] ref_mem [0:255];
  logic [255:0] ref_wr = '0;
  logic        m_last = 1'b1;
  bit          busy = 0;
  int          mv_cnt = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] m_gc0 = '0, m_gc1 = '0, m_conf = '0;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      busy      = 0;
      mv_cnt    = 0;
      m_last    = 1'b1;
      exp_rdata = '0;
      m_gc0 = '0; m_gc1 = '0; m_conf = '0;
    end else begin
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("spurious_rsp", {62'd0, rsp_valid}, 64'd0);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          if (!e.we) exp_rdata = e.rdata;
          check("rsp_owner", {62'd0, rsp_valid}, e.owner ? 64'd2 : 64'd1);
          check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
          check("rsp_latency", 64'(cyc - e.hs_cyc), 64'(2 + (e.we ? 0 : RL) + e.stall));
          check("issue_cycles", 64'(mv_cnt), 64'(1 + e.stall));
        end
        busy   = 0;
        mv_cnt = 0;
      end else begin
        if (rsp_rdata !== exp_rdata) check("rdata_hold", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
        if (busy) begin
          if (req_ready != 2'b00) check("ready_busy", {62'd0, req_ready}, 64'd0);
        end else if (req_valid != 2'b00) begin
          logic g;
          g = (&req_valid) ? ~m_last : req_valid[1];
          check("grant", {62'd0, req_ready}, g ? 64'd2 : 64'd1);
          cur.owner  = g;
          cur.we     = req_we[g];
          cur.addr   = g ? req_addr[63:32] : req_addr[31:0];
          cur.wdata  = g ? req_wdata[63:32] : req_wdata[31:0];
          cur.hs_cyc = cyc;
          cur.stall  = int'(stall_req);
          cur.rdata  = ref_wr[cur.addr[7:0]] ? ref_mem[cur.addr[7:0]] : init_val(cur.addr[7:0]);
          if (cur.we) begin
            ref_mem[cur.addr[7:0]] = cur.wdata;
            ref_wr[cur.addr[7:0]]  = 1'b1;
          end
          if (g) m_gc1 = m_gc1 + 1; else m_gc0 = m_gc0 + 1;
          if (&req_valid) m_conf = m_conf + 1;
          m_last = g;
          exp_q.push_back(cur);
          busy = 1;
        end
      end
      if (mem_valid) begin
        mv_cnt++;
        if (!busy) check("mem_valid_idle", 64'd1, 64'd0);
        else begin
          check("mem_addr", {32'd0, mem_addr}, {32'd0, cur.addr});
          check("mem_we", {63'd0, mem_write_enable}, {63'd0, cur.we});
          if (cur.we) check("mem_wdata", {32'd0, mem_write_data}, {32'd0, cur.wdata});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_we[r] = we;
    if (r == 1) begin req_addr[63:32] = a; req_wdata[63:32] = d; end
    else        begin req_addr[31:0]  = a; req_wdata[31:0]  = d; end
    req_valid[r] = 1'b1;
  endtask

  // Holds each asserted request until its handshake, then drops it.
  task automatic run_until_accepted(input logic [1:0] pend_in);
    logic [1:0] pend;
    logic [1:0] got;
    pend = pend_in;
    for (int k = 0; k < 200 && pend != 2'b00; k++) begin
      @(negedge clk);
      got = req_ready & pend;
      @(posedge clk); #1;
      req_valid = req_valid & ~got;
      pend      = pend & ~got;
    end
    if (pend != 2'b00) begin
      check("accept_timeout", {62'd0, pend}, 64'd0);
      req_valid = '0;
    end
  endtask

  task automatic solo(input int r, input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    drive(r, we, a, d);
    run_until_accepted(r == 1 ? 2'b10 : 2'b01);
  endtask

  task automatic both(input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk); #1;
    drive(0, w0, a0, d0);
    drive(1, w1, a1, d1);
    run_until_accepted(2'b11);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_valid", {63'd0, mem_valid}, 64'd0);
    check("reset_mem_we", {63'd0, mem_write_enable}, 64'd0);
    check("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("reset_mem_wdata", {32'd0, mem_write_data}, 64'd0);
    check("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    rst = 1'b1;

    // Basic read of a preloaded word.
    solo(0, 1'b0, 32'h10, 32'h0);
    drain();

    // Contention: req0 first after reset, then alternation.
    do_reset();
    both(1'b0, 32'h11, 32'h0, 1'b0, 32'h12, 32'h0);
    drain();
    both(1'b1, 32'h40, 32'h1111_0000, 1'b1, 32'h41, 32'h2222_0000);
    drain();
    both(1'b0, 32'h40, 32'h0, 1'b0, 32'h41, 32'h0);
    drain();

    // Stalled write from req1 leaves rsp_rdata unchanged.
    stall_req = 4;
    solo(1, 1'b1, 32'h20, 32'h0000_55AA);
    drain();
    stall_req = 0;
    solo(0, 1'b0, 32'h20, 32'h0);
    drain();

    // Single requester streaming.
    for (int i = 0; i < 4; i++) begin
      solo(1, 1'b0, 32'(8'h60 + i), 32'h0);
    end
    drain();

    // Reset in the cycle after memory accepted a read.
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h30, 32'h0);
    run_until_accepted(2'b01);
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (mem_valid && mem_ready) begin seen = 1; break; end
      end
      if (!seen) check("accept_wait_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    check("midrst_mem_valid", {63'd0, mem_valid}, 64'd0);
    @(posedge clk); #1;
    check("midrst_rsp_valid2", {62'd0, rsp_valid}, 64'd0);
    rst = 1'b1;
    both(1'b0, 32'h31, 32'h0, 1'b0, 32'h32, 32'h0);
    drain();

    // Mixed random traffic with random stalls.
    for (int i = 0; i < 20; i++) begin
      stall_req = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0)
        both(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
             1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      else
        solo(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom);
      drain();
    end
    stall_req = 0;

`ifdef DATA_MEMORY_ARBITER_STATS_EN
    do_reset();
    #1;
    check("stats_rst_gc0", {32'd0, grant_count0}, 64'd0);
    check("stats_rst_gc1", {32'd0, grant_count1}, 64'd0);
    check("stats_rst_conf", {32'd0, conflict_count}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      both(1'b0, 32'h70, 32'h0, 1'b0, 32'h71, 32'h0);
      drain();
    end
    solo(0, 1'b0, 32'h72, 32'h0);
    solo(0, 1'b0, 32'h73, 32'h0);
    drain();
    check("stats_gc0", {32'd0, grant_count0}, {32'd0, m_gc0});
    check("stats_gc1", {32'd0, grant_count1}, {32'd0, m_gc1});
    check("stats_conf", {32'd0, conflict_count}, 64'd3);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
